// File: rtl/glb_capture_pkg.sv
// Shared types and helpers for the global-buffer stream capture block.
package glb_capture_pkg;

  // Capture sequencer states.
  typedef enum logic [2:0] {
    IDLE,
    ARM,
    HDR,
    DATA,
    NEXT,
    DONE
  } cap_state_e;

  // Block-select width: at least one bit even when only one block exists.
  function automatic int calc_blk_w(input int num_blocks);
    return (num_blocks > 1) ? $clog2(num_blocks) : 1;
  endfunction

endpackage

// File: rtl/glb_capture_bank.sv
// One block of capture storage: DEPTH x DATA_WIDTH, single write port,
// registered read port with read-old-data behaviour on address collision.
module glb_capture_bank #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 1024,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_we,
  input  logic [ADDR_W-1:0]     i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_W-1:0]     i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Write port.
  // NOTE: the array has no reset so it maps onto RAM; only the read register is reset.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Registered read every cycle; a write to the same word this cycle is seen next cycle.
  always_ff @(posedge clk) begin
    if (rst) r_rdata <= '0;
    else     r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/glb_stream_capture.sv
// Sink for global-buffer read streams: after a flush pulse, captures
// NUM_BLOCKS length-prefixed blocks into per-block storage, flags headers
// longer than DEPTH, and offers a registered readback port.
module glb_stream_capture
  import glb_capture_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 1024,
  parameter int NUM_BLOCKS = 2,
  parameter int ADDR_W     = $clog2(DEPTH),
  parameter int BLK_W      = calc_blk_w(NUM_BLOCKS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  valid,
  output logic                  ready,
  output logic                  done,
  output logic                  error,
  input  logic [BLK_W-1:0]      rd_block,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] rd_len
);

  // One extra bit so a maximal header length can never wrap the word count.
  localparam int              CNT_W   = DATA_WIDTH + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  cap_state_e            r_state, w_state_next;
  logic [BLK_W-1:0]      r_blk;
  logic [CNT_W-1:0]      r_count;
  logic [DATA_WIDTH-1:0] r_cur_len;
  logic [DATA_WIDTH-1:0] r_len [NUM_BLOCKS];
  logic                  r_ready, r_done, r_error;
  logic                  w_xfer, w_last_blk, w_last_word, w_wr_en, w_rd_ok;
  logic [NUM_BLOCKS-1:0] w_we;
  logic [DATA_WIDTH-1:0] w_bank_q [NUM_BLOCKS];
  logic [BLK_W-1:0]      r_rd_block;
  logic                  r_rd_ok;
  logic [DATA_WIDTH-1:0] r_rd_len;

  // A word is taken only when no flush or reset is pending that cycle.
  assign w_xfer      = valid && r_ready && !flush && !rst;
  assign w_last_blk  = (int'(r_blk) == NUM_BLOCKS - 1);
  assign w_last_word = ((r_count + 1'b1) == {1'b0, r_cur_len});
  assign w_wr_en     = (r_state == DATA) && w_xfer && (r_count < DEPTH_C);
  assign w_rd_ok     = (int'(rd_block) < NUM_BLOCKS);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state decode; flush aborts any capture in progress.
  // NOTE: next state defaults to the current state first so no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (flush) w_state_next = ARM;
      ARM:  if (!flush) w_state_next = HDR;
      HDR: begin
        if (flush)       w_state_next = ARM;
        else if (w_xfer) w_state_next = (data == '0) ? NEXT : DATA;
      end
      DATA: begin
        if (flush)                      w_state_next = ARM;
        else if (w_xfer && w_last_word) w_state_next = NEXT;
      end
      NEXT: begin
        if (flush) w_state_next = ARM;
        else       w_state_next = w_last_blk ? DONE : HDR;
      end
      DONE:    if (flush) w_state_next = ARM;
      default: w_state_next = IDLE;
    endcase
  end

  // Handshake and status flags decoded from the next state, plus capture counters.
  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ready   <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
      r_blk     <= '0;
      r_count   <= '0;
      r_cur_len <= '0;
    end else begin
      r_ready <= (w_state_next == HDR) || (w_state_next == DATA);
      r_done  <= (w_state_next == DONE);
      case (r_state)
        ARM: begin
          r_error <= 1'b0;
          r_blk   <= '0;
        end
        HDR: begin
          if (w_xfer) begin
            r_count   <= '0;
            r_cur_len <= data;
            if ({1'b0, data} > DEPTH_C) r_error <= 1'b1;
          end
        end
        DATA: if (w_xfer) r_count <= r_count + 1'b1;
        NEXT: if (!flush && !w_last_blk) r_blk <= r_blk + 1'b1;
        default: ;
      endcase
    end
  end

  // Per-block captured lengths: cleared on arming, written by each header.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == ARM) begin
        for (int i = 0; i < NUM_BLOCKS; i++) r_len[i] <= '0;
      end else if (r_state == HDR && w_xfer) begin
        r_len[r_blk] <= data;
      end
    end
  end

  for (genvar g = 0; g < NUM_BLOCKS; g++) begin : g_bank
    assign w_we[g] = w_wr_en && (r_blk == BLK_W'(g));

    glb_capture_bank #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (DEPTH),
      .ADDR_W    (ADDR_W)
    ) u_bank (
      .clk    (clk),
      .rst    (rst),
      .i_we   (w_we[g]),
      .i_waddr(r_count[ADDR_W-1:0]),
      .i_wdata(data),
      .i_raddr(rd_addr),
      .o_rdata(w_bank_q[g])
    );
  end

  // Readback pipeline: block select and length registered alongside the bank read.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_block <= '0;
      r_rd_ok    <= 1'b0;
      r_rd_len   <= '0;
    end else begin
      r_rd_block <= rd_block;
      r_rd_ok    <= w_rd_ok;
      r_rd_len   <= w_rd_ok ? r_len[rd_block] : '0;
    end
  end

  assign rd_data = r_rd_ok ? w_bank_q[r_rd_block] : '0;
  assign rd_len  = r_rd_len;
  assign ready   = r_ready;
  assign done    = r_done;
  assign error   = r_error;

endmodule

// File: tb/tb_glb_stream_capture.sv
// Scoreboard bench for glb_stream_capture: random payloads and valid gaps,
// expected storage derived from the stream rules, readback checked by a monitor.
module tb_glb_stream_capture;

  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int NB    = 2;
  localparam int AW    = $clog2(DEPTH);
  localparam int BW    = 1;

  logic          clk = 1'b0;
  logic          rst, flush, valid, ready, done, error;
  logic [DW-1:0] data, rd_data, rd_len;
  logic [BW-1:0] rd_block;
  logic [AW-1:0] rd_addr;
  logic          rd_req;

  always #5 clk = ~clk;

  glb_stream_capture #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH),
    .NUM_BLOCKS(NB)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .data    (data),
    .valid   (valid),
    .ready   (ready),
    .done    (done),
    .error   (error),
    .rd_block(rd_block),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .rd_len  (rd_len)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: storage and lengths implied by a length-prefixed stream.
  logic [DW-1:0] m_mem [NB][DEPTH];
  logic [DW-1:0] m_len [NB];
  logic          m_err;
  logic [DW-1:0] stim [$];

  typedef struct {
    int            blk;
    int            addr;
    logic [DW-1:0] exp_data;
    logic [DW-1:0] exp_len;
    bit            chk_data;
  } rd_exp_t;
  rd_exp_t sb_q [$];

  function automatic void make_stream(input int l0, input int l1);
    stim.delete();
    stim.push_back(DW'(l0));
    for (int k = 0; k < l0; k++) stim.push_back(DW'($urandom));
    stim.push_back(DW'(l1));
    for (int k = 0; k < l1; k++) stim.push_back(DW'($urandom));
  endfunction

  function automatic void model_capture();
    int idx;
    idx   = 0;
    m_err = 1'b0;
    for (int b = 0; b < NB; b++) begin
      int len;
      len      = int'(stim[idx]);
      m_len[b] = stim[idx];
      idx++;
      if (len > DEPTH) m_err = 1'b1;
      for (int k = 0; k < len; k++) begin
        if (k < DEPTH) m_mem[b][k] = stim[idx];
        idx++;
      end
    end
  endfunction

  // Offer one word, optionally after random idle cycles; returns cycles spent waiting on ready.
  task automatic send_word(input logic [DW-1:0] w, input int gap_pct, output int cyc);
    logic r0;
    while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
      valid = 1'b0;
      data  = DW'($urandom);
      @(negedge clk);
    end
    r0    = ready;
    valid = 1'b1;
    data  = w;
    #1;
    check("ready_vs_valid", ready, r0);
    cyc = 0;
    while (!ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("ready_wait", ready, 1'b1);
    @(negedge clk);
  endtask

  task automatic send_stream(input int gap_pct, output int waits);
    int c;
    waits = 0;
    foreach (stim[i]) begin
      send_word(stim[i], gap_pct, c);
      waits += c;
    end
    valid = 1'b0;
    data  = '0;
  endtask

  task automatic flush_pulse();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_done();
    int cyc;
    cyc = 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("done", done, 1'b1);
  endtask

  // Issue readback requests; expected values go to the scoreboard.
  task automatic read_block(input int b, input int n);
    int cnt;
    cnt = (n == 0) ? 1 : n;
    for (int a = 0; a < cnt; a++) begin
      rd_block = BW'(b);
      rd_addr  = AW'(a);
      rd_req   = 1'b1;
      sb_q.push_back('{b, a, m_mem[b][a], m_len[b], n != 0});
      @(negedge clk);
    end
    rd_req = 1'b0;
  endtask

  // Monitor: one cycle after each sampled request, compare against the scoreboard head.
  initial begin
    rd_exp_t e;
    forever begin
      @(posedge clk);
      if (rd_req) begin
        #1;
        check("sb_nonempty", 32'(sb_q.size() > 0), 1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          if (e.chk_data) check($sformatf("rd_data[%0d][%0d]", e.blk, e.addr), rd_data, e.exp_data);
          check($sformatf("rd_len[%0d]", e.blk), rd_len, e.exp_len);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int waits, c;
    rst = 1'b1; flush = 1'b0; valid = 1'b0; data = '0;
    rd_block = '0; rd_addr = '0; rd_req = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", ready, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_rd_len", rd_len, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", ready, 0);

    // Two blocks, valid always high.
    flush_pulse();
    make_stream(4, 3);
    model_capture();
    send_stream(0, waits);
    check("bubble_cycles", waits, 1);
    check("done_during_next", done, 0);
    @(negedge clk);
    check("done_rise", done, 1);
    check("error_t1", error, 0);
    check("ready_in_done", ready, 0);
    read_block(0, 4);
    read_block(1, 3);

    // Same shape with random valid gaps.
    flush_pulse();
    check("done_cleared", done, 0);
    make_stream(4, 3);
    model_capture();
    send_stream(50, waits);
    wait_done();
    check("error_t2", error, 0);
    read_block(0, 4);
    read_block(1, 3);

    // Zero-length first block.
    flush_pulse();
    make_stream(0, 2);
    model_capture();
    send_stream(30, waits);
    wait_done();
    read_block(0, 0);
    read_block(1, 2);

    // Over-length header: only DEPTH words stored, all accepted.
    flush_pulse();
    make_stream(10, 1);
    model_capture();
    send_stream(30, waits);
    wait_done();
    check("error_over", error, 32'(m_err));
    read_block(0, DEPTH);
    read_block(1, 1);
    flush_pulse();
    check("error_cleared", error, 0);

    // Abort after two of five data words, then a fresh capture.
    send_word(DW'(5), 0, c);
    send_word(DW'($urandom), 0, c);
    send_word(DW'($urandom), 0, c);
    valid = 1'b0;
    flush_pulse();
    make_stream(1, 1);
    model_capture();
    send_stream(0, waits);
    wait_done();
    read_block(0, 1);
    read_block(1, 1);

    // Reset in DATA with flush and valid asserted in the same cycle.
    flush_pulse();
    send_word(DW'(9), 0, c);
    send_word(DW'($urandom), 0, c);
    send_word(DW'($urandom), 0, c);
    check("err_before_rst", error, 1);
    rst = 1'b1; flush = 1'b1; valid = 1'b1;
    @(negedge clk);
    rst = 1'b0; flush = 1'b0; valid = 1'b0;
    check("rst2_ready", ready, 0);
    check("rst2_done", done, 0);
    check("rst2_error", error, 0);
    check("rst2_rd_data", rd_data, 0);
    check("rst2_rd_len", rd_len, 0);
    @(negedge clk);
    check("rst2_stays_idle", ready, 0);
    flush_pulse();
    make_stream(2, 3);
    model_capture();
    send_stream(50, waits);
    wait_done();
    check("error_t6", error, 0);
    read_block(0, 2);
    read_block(1, 3);

    repeat (3) @(negedge clk);
    check("sb_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
